// File: rtl/sum_frame_accumulator.sv
// rtl/sum_frame_accumulator.sv - frames a stream of adder sums into total/peak/count/saturation results
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid, in_data     incoming unsigned sum samples (IN_W bits)
//   in_ready              high whenever no result is pending
//   frame_len             samples per frame, sampled at the first beat (0 means 1)
//   flush                 closes the current frame early
//   out_valid, out_ready  result handshake
//   out_total             saturated frame sum (ACC_W bits)
//   out_peak              largest sample of the frame
//   out_count             number of samples in the frame
//   out_sat               accumulator clipped at least once during the frame
`timescale 1ns/1ps
module sum_frame_accumulator #(
  parameter int IN_W  = 15,
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [IN_W-1:0]  out_peak,
  output logic [LEN_W-1:0] out_count,
  output logic             out_sat
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [IN_W-1:0]  peak;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             sat;

  logic             beat;
  logic [ACC_W:0]   sum_wide;
  logic             clip;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] data_ext;
  logic [IN_W-1:0]  peak_max;
  logic [LEN_W-1:0] cnt_inc;
  logic [LEN_W-1:0] len_eff;

  assign in_ready = (state != S_HOLD);
  assign beat     = in_valid && in_ready;

  // One extra bit of headroom so the carry out tells us the sum clipped.
  assign sum_wide = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
  assign clip     = sum_wide[ACC_W];
  assign acc_sum  = clip ? ACC_MAX : sum_wide[ACC_W-1:0];
  assign data_ext = {{(ACC_W - IN_W){1'b0}}, in_data};
  assign peak_max = (in_data > peak) ? in_data : peak;
  assign cnt_inc  = cnt + LEN_W'(1);
  assign len_eff  = (frame_len == '0) ? LEN_W'(1) : frame_len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      peak      <= '0;
      cnt       <= '0;
      len_q     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_total <= '0;
      out_peak  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (beat) begin
            len_q <= len_eff;
            acc   <= data_ext;
            peak  <= in_data;
            cnt   <= LEN_W'(1);
            sat   <= 1'b0;
            state <= ((len_eff == LEN_W'(1)) || flush) ? S_HOLD : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc  <= acc_sum;
            sat  <= sat | clip;
            peak <= peak_max;
            cnt  <= cnt_inc;
            // A flush coincident with a beat still includes that beat.
            if ((cnt_inc == len_q) || flush) begin
              state <= S_HOLD;
            end
          end else if (flush) begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // First HOLD cycle publishes the frame; the result is then held
          // until the consumer takes it.
          if (!out_valid) begin
            out_total <= acc;
            out_peak  <= peak;
            out_count <= cnt;
            out_sat   <= sat;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
            acc       <= '0;
            peak      <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// tb/tb_sum_frame_accumulator.sv - self-checking bench for sum_frame_accumulator
`timescale 1ns/1ps
module tb_sum_frame_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [14:0] in_data;
  logic        in_ready;
  logic [7:0]  frame_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_total;
  logic [14:0] out_peak;
  logic [7:0]  out_count;
  logic        out_sat;

  logic        in_ready16;
  logic        out_valid16;
  logic [15:0] out_total16;
  logic [14:0] out_peak16;
  logic [7:0]  out_count16;
  logic        out_sat16;

  sum_frame_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .frame_len(frame_len), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_total(out_total),
    .out_peak(out_peak), .out_count(out_count), .out_sat(out_sat)
  );

  // Narrow accumulator copy sharing the same stimulus, used for saturation.
  sum_frame_accumulator #(.IN_W(15), .ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready16), .frame_len(frame_len), .flush(flush),
    .out_valid(out_valid16), .out_ready(out_ready), .out_total(out_total16),
    .out_peak(out_peak16), .out_count(out_count16), .out_sat(out_sat16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] tot;
    logic [14:0] pk;
    logic [7:0]  cnt;
    logic        sat;
  } exp_t;

  typedef struct {
    logic [7:0]  len;
    int          n;
    logic [14:0] d[4];
    bit          flush_beat;
    bit          flush_alone;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Scoreboard: every completed handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_total", 32'(out_total), 32'(e.tot));
        chk("out_peak",  32'(out_peak),  32'(e.pk));
        chk("out_count", 32'(out_count), 32'(e.cnt));
        chk("out_sat",   32'(out_sat),   32'(e.sat));
      end
    end
  end

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send_beat(input logic [14:0] d, input logic fl);
    int  t;
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) chk("beat_accept_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    frame_len = v.len;
    sb.push_back(v.e);
    for (int j = 0; j < v.n; j++) begin
      send_beat(v.d[j], v.flush_beat && (j == v.n - 1));
    end
    if (v.flush_alone) begin
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0] = '{8'd4, 4, '{15'd100, 15'd200, 15'd300, 15'd400}, 1'b0, 1'b0, '{24'd1000, 15'd400, 8'd4, 1'b0}};
    vecs[1] = '{8'd0, 1, '{15'd32767, 15'd0, 15'd0, 15'd0}, 1'b0, 1'b0, '{24'd32767, 15'd32767, 8'd1, 1'b0}};
    vecs[2] = '{8'd3, 3, '{15'd32767, 15'd32767, 15'd32767, 15'd0}, 1'b0, 1'b0, '{24'd98301, 15'd32767, 8'd3, 1'b0}};
    vecs[3] = '{8'd8, 2, '{15'd10, 15'd20, 15'd0, 15'd0}, 1'b0, 1'b1, '{24'd30, 15'd20, 8'd2, 1'b0}};
    vecs[4] = '{8'd8, 3, '{15'd10, 15'd20, 15'd5, 15'd0}, 1'b1, 1'b0, '{24'd35, 15'd20, 8'd3, 1'b0}};
    vecs[5] = '{8'd1, 1, '{15'd5, 15'd0, 15'd0, 15'd0}, 1'b0, 1'b0, '{24'd5, 15'd5, 8'd1, 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; frame_len = 8'd4;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_total", 32'(out_total), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_sat",   32'(out_sat),   32'd0);
    @(posedge clk); #1;

    // Latency and in_ready timing around a 4-beat frame.
    frame_len = 8'd4;
    sb.push_back('{24'd1000, 15'd400, 8'd4, 1'b0});
    send_beat(15'd100, 1'b0);
    send_beat(15'd200, 1'b0);
    send_beat(15'd300, 1'b0);
    send_beat(15'd400, 1'b0);
    @(negedge clk);
    chk("lat_t0_out_valid", 32'(out_valid), 32'd0);
    chk("lat_t0_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    chk("lat_t1_out_valid", 32'(out_valid), 32'd1);
    chk("lat_t1_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    chk("lat_t2_out_valid", 32'(out_valid), 32'd0);
    chk("lat_t2_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    drain();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure: result held, pending beat 55 must not be consumed.
    out_ready = 1'b0;
    frame_len = 8'd2;
    send_beat(15'd7, 1'b0);
    send_beat(15'd9, 1'b0);
    in_valid  = 1'b1;
    in_data   = 15'd55;
    frame_len = 8'd1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_total",     32'(out_total), 32'd16);
      chk("stall_peak",      32'(out_peak),  32'd9);
      chk("stall_count",     32'(out_count), 32'd2);
    end
    @(posedge clk); #1;
    sb.push_back('{24'd16, 15'd9, 8'd2, 1'b0});
    sb.push_back('{24'd55, 15'd55, 8'd1, 1'b0});
    out_ready = 1'b1;
    send_beat(15'd55, 1'b0);
    drain();

    // Reset mid-frame discards the partial frame.
    frame_len = 8'd4;
    send_beat(15'd1000, 1'b0);
    send_beat(15'd1000, 1'b0);
    send_beat(15'd1000, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    end
    chk("post_rst_out_total", 32'(out_total), 32'd0);
    @(posedge clk); #1;
    sb.push_back('{24'd4, 15'd1, 8'd4, 1'b0});
    for (int k = 0; k < 4; k++) send_beat(15'd1, 1'b0);
    drain();

    // Saturation on the 16-bit accumulator copy.
    frame_len = 8'd3;
    e = '{24'd98301, 15'd32767, 8'd3, 1'b0};
    sb.push_back(e);
    for (int k = 0; k < 3; k++) send_beat(15'd32767, 1'b0);
    drain();
    @(negedge clk);
    chk("sat16_total",     32'(out_total16), 32'd65535);
    chk("sat16_sat",       32'(out_sat16),   32'd1);
    chk("sat16_count",     32'(out_count16), 32'd3);
    chk("sat16_peak",      32'(out_peak16),  32'd32767);
    chk("sat16_out_valid", 32'(out_valid16), 32'd0);
    chk("sat16_in_ready",  32'(in_ready16),  32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
